// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the MEM-stage / DMA port arbiter in front of the data aligner.
package mem_arb_pkg;

  localparam int ARB_N = 32;
  localparam int ARB_V = 256;

  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  typedef struct packed {
    logic             rd;
    logic             wr;
    logic             vec;
    logic [31:0]      addr;
    logic [15:0]      wdata_s;
    logic [ARB_V-1:0] wdata_v;
  } mem_cmd_t;

  localparam mem_cmd_t CMD_NONE = '0;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU, DMA and aligner signals around the port arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int N = ARB_N,
  parameter int V = ARB_V
);
  logic         cpu_rd;
  logic         cpu_wr;
  logic         cpu_vec;
  logic [31:0]  cpu_addr;
  logic [15:0]  cpu_wdata_s;
  logic [V-1:0] cpu_wdata_v;
  logic         cpu_stall;
  logic         cpu_done;
  logic [N-1:0] cpu_rdata_s;
  logic [V-1:0] cpu_rdata_v;

  logic         dma_req;
  logic         dma_we;
  logic         dma_vec;
  logic [31:0]  dma_addr;
  logic [15:0]  dma_wdata_s;
  logic [V-1:0] dma_wdata_v;
  logic         dma_gnt;
  logic         dma_done;
  logic [N-1:0] dma_rdata_s;
  logic [V-1:0] dma_rdata_v;

  logic         al_memtoReg;
  logic         al_memWrite;
  logic         al_memSrc;
  logic [31:0]  al_address;
  logic [15:0]  al_wdata_s;
  logic [V-1:0] al_wdata_v;
  logic         al_busy;
  logic [N-1:0] al_rdata_s;
  logic [V-1:0] al_rdata_v;

  logic         err;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_vec, cpu_addr, cpu_wdata_s, cpu_wdata_v,
    output cpu_stall, cpu_done, cpu_rdata_s, cpu_rdata_v,
    input  dma_req, dma_we, dma_vec, dma_addr, dma_wdata_s, dma_wdata_v,
    output dma_gnt, dma_done, dma_rdata_s, dma_rdata_v,
    output al_memtoReg, al_memWrite, al_memSrc, al_address, al_wdata_s, al_wdata_v,
    input  al_busy, al_rdata_s, al_rdata_v,
    output err
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_vec, cpu_addr, cpu_wdata_s, cpu_wdata_v,
    input  cpu_stall, cpu_done, cpu_rdata_s, cpu_rdata_v,
    output dma_req, dma_we, dma_vec, dma_addr, dma_wdata_s, dma_wdata_v,
    input  dma_gnt, dma_done, dma_rdata_s, dma_rdata_v,
    input  al_memtoReg, al_memWrite, al_memSrc, al_address, al_wdata_s, al_wdata_v,
    output al_busy, al_rdata_s, al_rdata_v,
    input  err
  );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && cnt_reg != MAX_C) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single aligner port between the CPU MEM stage and the DMA loader,
// holding the granted command until the aligner finishes or the op times out.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int V        = ARB_V,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 6
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int WAIT_W = cnt_width(MAX_WAIT);
  localparam int TMO_W  = cnt_width(TIMEOUT);

  state_t       state_reg;
  owner_t       owner_reg;
  mem_cmd_t     cmd_reg;
  logic         cpu_done_reg;
  logic         dma_done_reg;
  logic         dma_gnt_reg;
  logic         err_reg;
  logic [N-1:0] cpu_rdata_s_reg;
  logic [V-1:0] cpu_rdata_v_reg;
  logic [N-1:0] dma_rdata_s_reg;
  logic [V-1:0] dma_rdata_v_reg;

  mem_cmd_t          cpu_cmd;
  mem_cmd_t          dma_cmd;
  logic              cpu_cand;
  logic              dma_win;
  logic              is_idle;
  logic              tmo_hit;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  // The done pulse masks the CPU request so the access just completed is not re-granted.
  assign cpu_cand = (bus.cpu_rd | bus.cpu_wr) & ~cpu_done_reg;
  assign dma_win  = bus.dma_req & (~cpu_cand | (wait_cnt == WAIT_W'(MAX_WAIT)));
  assign is_idle  = (state_reg == IDLE);
  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_comb begin
    cpu_cmd         = CMD_NONE;
    cpu_cmd.rd      = bus.cpu_rd & ~bus.cpu_wr;
    cpu_cmd.wr      = bus.cpu_wr;
    cpu_cmd.vec     = bus.cpu_vec;
    cpu_cmd.addr    = bus.cpu_addr;
    cpu_cmd.wdata_s = bus.cpu_wdata_s;
    cpu_cmd.wdata_v = bus.cpu_wdata_v;

    dma_cmd         = CMD_NONE;
    dma_cmd.rd      = ~bus.dma_we;
    dma_cmd.wr      = bus.dma_we;
    dma_cmd.vec     = bus.dma_vec;
    dma_cmd.addr    = bus.dma_addr;
    dma_cmd.wdata_s = bus.dma_wdata_s;
    dma_cmd.wdata_v = bus.dma_wdata_v;
  end

  sat_counter #(.WIDTH(WAIT_W), .MAX(MAX_WAIT)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (is_idle & dma_win),
    .inc (is_idle & bus.dma_req & ~dma_win),
    .cnt (wait_cnt)
  );

  sat_counter #(.WIDTH(TMO_W), .MAX(TIMEOUT)) u_tmo_cnt (
    .clk (clk),
    .rst (rst),
    .clr (is_idle),
    .inc (~is_idle),
    .cnt (tmo_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      owner_reg       <= OWN_CPU;
      cmd_reg         <= CMD_NONE;
      cpu_done_reg    <= 1'b0;
      dma_done_reg    <= 1'b0;
      dma_gnt_reg     <= 1'b0;
      err_reg         <= 1'b0;
      cpu_rdata_s_reg <= '0;
      cpu_rdata_v_reg <= '0;
      dma_rdata_s_reg <= '0;
      dma_rdata_v_reg <= '0;
    end else begin
      cpu_done_reg <= 1'b0;
      dma_done_reg <= 1'b0;
      dma_gnt_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cpu_cand | bus.dma_req) begin
            state_reg <= ACTIVE;
            if (dma_win) begin
              cmd_reg     <= dma_cmd;
              owner_reg   <= OWN_DMA;
              dma_gnt_reg <= 1'b1;
            end else begin
              cmd_reg   <= cpu_cmd;
              owner_reg <= OWN_CPU;
            end
          end
        end
        ACTIVE: begin
          // Clearing the latch on completion is what returns al_* to 0 in IDLE.
          if (!bus.al_busy || tmo_hit) begin
            state_reg <= IDLE;
            cmd_reg   <= CMD_NONE;
            if (owner_reg == OWN_CPU) cpu_done_reg <= 1'b1;
            else                      dma_done_reg <= 1'b1;
            if (bus.al_busy) begin
              err_reg <= 1'b1;
              if (owner_reg == OWN_CPU) begin
                cpu_rdata_s_reg <= '0;
                cpu_rdata_v_reg <= '0;
              end else begin
                dma_rdata_s_reg <= '0;
                dma_rdata_v_reg <= '0;
              end
            end else if (cmd_reg.rd) begin
              if (owner_reg == OWN_CPU) begin
                cpu_rdata_s_reg <= bus.al_rdata_s;
                cpu_rdata_v_reg <= bus.al_rdata_v;
              end else begin
                dma_rdata_s_reg <= bus.al_rdata_s;
                dma_rdata_v_reg <= bus.al_rdata_v;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cpu_stall   = (bus.cpu_rd | bus.cpu_wr) & ~cpu_done_reg;
  assign bus.cpu_done    = cpu_done_reg;
  assign bus.cpu_rdata_s = cpu_rdata_s_reg;
  assign bus.cpu_rdata_v = cpu_rdata_v_reg;
  assign bus.dma_gnt     = dma_gnt_reg;
  assign bus.dma_done    = dma_done_reg;
  assign bus.dma_rdata_s = dma_rdata_s_reg;
  assign bus.dma_rdata_v = dma_rdata_v_reg;
  assign bus.al_memtoReg = cmd_reg.rd;
  assign bus.al_memWrite = cmd_reg.wr;
  assign bus.al_memSrc   = cmd_reg.vec;
  assign bus.al_address  = cmd_reg.addr;
  assign bus.al_wdata_s  = cmd_reg.wdata_s;
  assign bus.al_wdata_v  = cmd_reg.wdata_v;
  assign bus.err         = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural aligner model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic force_busy;
  int   al_k;
  int   al_lat;
  logic model_busy;
  int   n_checks;
  int   n_errors;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Aligner model: busy for (latency-1) cycles of an asserted command.
  initial al_k = 0;
  always @(posedge clk) begin
    if (bus.al_memtoReg || bus.al_memWrite) al_k <= al_k + 1;
    else                                    al_k <= 0;
  end

  always_comb begin
    al_lat = 1;
    if (bus.al_memtoReg) al_lat = 2;
    if (bus.al_memSrc && bus.al_address[4:0] != 5'd0) al_lat = al_lat + 1;
    model_busy = (bus.al_memtoReg || bus.al_memWrite) && (al_k < al_lat - 1);
  end

  assign bus.al_busy    = force_busy | model_busy;
  assign bus.al_rdata_s = (bus.al_address == 32'h40) ? 32'hDEADBEEF : (bus.al_address ^ 32'h5A5A0000);
  assign bus.al_rdata_v = {8{bus.al_address ^ 32'h12345678}};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input bit for_dma, input int limit, output int n);
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      @(negedge clk);
      n++;
      got = for_dma ? bus.dma_done : bus.cpu_done;
    end
    if (!got) check(for_dma ? "dma_done_timeout" : "cpu_done_timeout", got, 1);
  endtask

  // Issues one CPU access from a negedge; returns grant-to-done latency, stall cycles
  // after grant, and {memtoReg, memWrite, memSrc} seen in the first ACTIVE cycle.
  task automatic cpu_op(input logic rd, input logic wr, input logic vec, input logic [31:0] addr,
                        output int lat, output int stalls, output logic [2:0] ctl);
    int n;
    bit got;
    bus.cpu_rd      = rd;
    bus.cpu_wr      = wr;
    bus.cpu_vec     = vec;
    bus.cpu_addr    = addr;
    bus.cpu_wdata_s = addr[15:0];
    n = 0;
    got = 1'b0;
    stalls = 0;
    ctl = 3'b000;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) ctl = {bus.al_memtoReg, bus.al_memWrite, bus.al_memSrc};
      if (bus.cpu_done) got = 1'b1;
      else if (bus.cpu_stall) stalls++;
    end
    if (!got) check("cpu_op_timeout", got, 1);
    lat = n - 1;
    $display("txn cpu rd=%0d wr=%0d vec=%0d addr=%h lat=%0d rdata_s=%h", rd, wr, vec, addr, lat, bus.cpu_rdata_s);
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int stalls;
    int n;
    int cnt_a;
    int cnt_b;
    int ev;
    logic [2:0]   ctl;
    logic [9:0]   seq;
    logic [255:0] vpat;

    n_checks = 0;
    n_errors = 0;
    force_busy = 1'b0;
    rst = 1'b0;
    bus.cpu_rd = 1'b0;  bus.cpu_wr = 1'b0;  bus.cpu_vec = 1'b0;
    bus.cpu_addr = '0;  bus.cpu_wdata_s = '0;  bus.cpu_wdata_v = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0;  bus.dma_vec = 1'b0;
    bus.dma_addr = '0;  bus.dma_wdata_s = '0;  bus.dma_wdata_v = '0;

    repeat (2) @(negedge clk);
    check("rst_cpu_done", bus.cpu_done, 0);
    check("rst_dma_gnt", bus.dma_gnt, 0);
    check("rst_al_ctl", {bus.al_memtoReg, bus.al_memWrite, bus.al_memSrc}, 0);
    check("rst_err", bus.err, 0);
    check("rst_cpu_stall", bus.cpu_stall, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: CPU scalar read of 0x40
    cpu_op(1'b1, 1'b0, 1'b0, 32'h40, lat, stalls, ctl);
    check("rd_s_ctl", ctl, 3'b100);
    check("rd_s_latency", lat, 2);
    check("rd_s_stall_cycles", stalls, 2);
    check("rd_s_rdata", bus.cpu_rdata_s, 32'hDEADBEEF);

    // rd and wr together: write wins, rdata left alone
    cpu_op(1'b1, 1'b1, 1'b0, 32'h44, lat, stalls, ctl);
    check("wr_wins_ctl", ctl, 3'b010);
    check("wr_s_latency", lat, 1);
    check("wr_keeps_rdata", bus.cpu_rdata_s, 32'hDEADBEEF);

    // Unaligned vector read
    cpu_op(1'b1, 1'b0, 1'b1, 32'h30, lat, stalls, ctl);
    check("rd_v_ctl", ctl, 3'b101);
    check("rd_v_latency", lat, 3);
    check("rd_v_rdata_v", bus.cpu_rdata_v, {8{32'h12345648}});
    check("rd_v_rdata_s", bus.cpu_rdata_s, 32'h5A5A0030);

    // 2: DMA unaligned vector write to 0x30; fields scrambled right after the grant
    vpat = {8{32'hC0FFEE01}};
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_vec = 1'b1;
    bus.dma_addr = 32'h30; bus.dma_wdata_v = vpat;
    n = 0; cnt_a = 0; cnt_b = 0; ev = 0;
    while (ev == 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("dma_wr_addr", bus.al_address, 32'h30);
        check("dma_wr_wdata_v", bus.al_wdata_v, vpat);
        check("dma_wr_memSrc", bus.al_memSrc, 1);
        check("dma_wr_cpu_stall", bus.cpu_stall, 0);
      end
      if (n == 2) check("dma_wr_latched_addr", bus.al_address, 32'h30);
      if (bus.dma_gnt) begin
        cnt_a++;
        bus.dma_req = 1'b0; bus.dma_addr = 32'hFFFFFFFF; bus.dma_wdata_v = '0;
      end
      if (bus.al_memWrite) cnt_b++;
      if (bus.dma_done) ev = 1;
    end
    check("dma_wr_done_seen", ev, 1);
    check("dma_wr_latency", n - 1, 2);
    check("dma_gnt_cycles", cnt_a, 1);
    check("dma_memWrite_cycles", cnt_b, 2);
    check("dma_wr_rdata_v", bus.dma_rdata_v, 0);
    $display("txn dma wr vec addr=30 lat=%0d", n - 1);
    bus.dma_we = 1'b0; bus.dma_vec = 1'b0;
    @(negedge clk);

    // 3: both request continuously; DMA steps aside only in the CPU's done cycle
    bus.dma_addr = 32'h80;
    bus.cpu_addr = 32'h44; bus.cpu_vec = 1'b0; bus.cpu_rd = 1'b1;
    bus.dma_req = 1'b1;
    seq = '0; ev = 0; n = 0;
    while (ev < 10 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.cpu_done || bus.dma_done) begin
        seq[ev] = bus.dma_done;
        ev++;
      end
      bus.dma_req = ~bus.cpu_done;
    end
    bus.cpu_rd = 1'b0; bus.dma_req = 1'b0;
    check("arb_done_count", ev, 10);
    check("arb_order", seq, 10'b1000010000);
    check("arb_cpu_rdata", bus.cpu_rdata_s, 32'h5A5A0044);
    check("arb_dma_rdata", bus.dma_rdata_s, 32'h5A5A0080);
    $display("txn arb sequence (1=dma) %b", seq);
    @(negedge clk);

    // 4: read held through the done cycle
    bus.cpu_addr = 32'h40; bus.cpu_rd = 1'b1;
    wait_done(1'b0, 20, n);
    @(negedge clk);
    check("hold_no_regrant", bus.al_memtoReg, 0);
    check("hold_stall", bus.cpu_stall, 1);
    @(negedge clk);
    check("hold_regrant", bus.al_memtoReg, 1);
    wait_done(1'b0, 20, n);
    check("hold_rdata", bus.cpu_rdata_s, 32'hDEADBEEF);
    $display("txn cpu held read addr=40 regranted");
    bus.cpu_rd = 1'b0;
    @(negedge clk);

    // 5: aligner stuck busy -> timeout abort
    force_busy = 1'b1;
    bus.cpu_rd = 1'b1;
    n = 0; cnt_a = 0; ev = 0;
    while (ev == 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.al_memtoReg) cnt_a++;
      if (bus.cpu_done) ev = 1;
    end
    check("abort_done", ev, 1);
    check("abort_active_cycles", cnt_a, 6);
    check("abort_rdata", bus.cpu_rdata_s, 0);
    check("abort_err", bus.err, 1);
    $display("txn cpu read aborted after %0d active cycles", cnt_a);
    bus.cpu_rd = 1'b0; force_busy = 1'b0;
    @(negedge clk);
    cpu_op(1'b1, 1'b0, 1'b0, 32'h40, lat, stalls, ctl);
    check("post_abort_rdata", bus.cpu_rdata_s, 32'hDEADBEEF);
    check("err_sticky", bus.err, 1);

    // 6: reset mid-ACTIVE
    bus.cpu_addr = 32'h48; bus.cpu_rd = 1'b1;
    @(negedge clk);
    check("pre_rst_active", bus.al_memtoReg, 1);
    #2;
    rst = 1'b0; bus.cpu_rd = 1'b0;
    #1;
    check("mid_rst_al_ctl", bus.al_memtoReg, 0);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_rdata", bus.cpu_rdata_s, 0);
    check("mid_rst_done", bus.cpu_done, 0);
    @(negedge clk);
    rst = 1'b1;
    cnt_a = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.cpu_done) cnt_a++;
    end
    check("rst_no_done", cnt_a, 0);
    $display("txn reset mid-active, dropped op");
    cpu_op(1'b1, 1'b0, 1'b0, 32'h40, lat, stalls, ctl);
    check("post_rst_latency", lat, 2);
    check("post_rst_rdata", bus.cpu_rdata_s, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
